counter_bank: RTL and testbench



---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_ch.sv | 60 ++++++
 rtl/counter_bank.sv | 56 +++++
 tb/tb_counter_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter bank.
// Holds the mode encodings and the flattened-bus slice helper.
package counter_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/counter_ch.sv
// One counter channel: count, hit pulse and sticky overrun.
// Terminal count and mode come from shared config registers.
module counter_ch
  import counter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clean,
  input  logic             en,
  input  logic [CNT_W-1:0] max_r,
  input  logic             mode_r,
  output logic [CNT_W-1:0] count,
  output logic             flag,
  output logic             hit,
  output logic             ovf
);

  logic             term;
  logic [CNT_W-1:0] count_nxt;
  logic             hit_nxt;
  logic             ovf_set;

  assign term = (count >= max_r);
  assign flag = term;

  always_comb begin
    count_nxt = count;
    ovf_set   = 1'b0;
    if (en) begin
      unique case (1'b1)
        !term: count_nxt = count + CNT_W'(1);
        term && (mode_r == MODE_WRAP): count_nxt = '0;
        default: ovf_set = 1'b1;
      endcase
    end
  end

  // A held count at max only re-hits in wrap mode (max_r == 0).
  assign hit_nxt = en && (count_nxt == max_r) &&
                   ((count_nxt != count) || (mode_r == MODE_WRAP));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      hit   <= 1'b0;
      ovf   <= 1'b0;
    end else if (clean) begin
      count <= '0;
      hit   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      hit   <= hit_nxt;
      if (ovf_set) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of independent event counters sharing one terminal count
// and mode; config registers live here, channels are replicated.
module counter_bank
  import counter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_MAX = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       clean,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    cfg_we,
  input  logic [CNT_W-1:0]        cfg_max,
  input  logic                    cfg_mode,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       flag,
  output logic [NUM_CH-1:0]       hit,
  output logic [NUM_CH-1:0]       ovf,
  output logic                    all_flag
);

  logic [CNT_W-1:0] max_r;
  logic             mode_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_r  <= CNT_W'(DEFAULT_MAX);
      mode_r <= MODE_SAT;
    end else if (cfg_we) begin
      max_r  <= cfg_max;
      mode_r <= cfg_mode;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .clean (clean[i]),
      .en    (en[i]),
      .max_r (max_r),
      .mode_r(mode_r),
      .count (count[slice_lo(i, CNT_W) +: CNT_W]),
      .flag  (flag[i]),
      .hit   (hit[i]),
      .ovf   (ovf[i])
    );
  end

  assign all_flag = &flag;

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank.
// Expected values are hand-computed per scenario.
module tb_counter_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       clean;
  logic [NUM_CH-1:0]       en;
  logic                    cfg_we;
  logic [CNT_W-1:0]        cfg_max;
  logic                    cfg_mode;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       flag;
  logic [NUM_CH-1:0]       hit;
  logic [NUM_CH-1:0]       ovf;
  logic                    all_flag;

  int n_chk  = 0;
  int n_fail = 0;
  int hits;

  counter_bank #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_MAX(100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clean   (clean),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_max (cfg_max),
    .cfg_mode(cfg_mode),
    .count   (count),
    .flag    (flag),
    .hit     (hit),
    .ovf     (ovf),
    .all_flag(all_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  task automatic cfg(input logic [CNT_W-1:0] m, input logic md);
    cfg_we   = 1'b1;
    cfg_max  = m;
    cfg_mode = md;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] wexp [8];
    wexp = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    rst_n = 1'b0; clean = '0; en = '0;
    cfg_we = 1'b0; cfg_max = '0; cfg_mode = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_count", count, 0);
    check("rst_flag", flag, 0);
    check("rst_hit", hit, 0);
    check("rst_ovf", ovf, 0);
    check("rst_all_flag", all_flag, 0);

    // Count ch0 up to the default max of 100.
    en = 4'b0001;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hit[0]) hits++;
      if (i == 99) check("t1_hit_last", hit[0], 1);
    end
    check("t1_hits", hits, 1);
    check("t1_count0", cnt(0), 100);
    check("t1_flag0", flag[0], 1);
    tick();
    check("t1_sat_count0", cnt(0), 100);
    check("t1_ovf0", ovf[0], 1);
    check("t1_sat_hit0", hit[0], 0);
    en = '0;

    // Wrap mode, max 3 on ch1.
    cfg(8'd3, 1'b1);
    en = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_count1", cnt(1), wexp[i]);
      check("t2_hit1", hit[1], (wexp[i] == 3) ? 1 : 0);
      check("t2_ovf1", ovf[1], 0);
    end
    en = '0;

    // Lower max below a live count in saturate mode.
    cfg(8'd100, 1'b0);
    en = 4'b0100;
    repeat (5) tick();
    en = '0;
    check("t3_count2", cnt(2), 5);
    check("t3_flag2_lo", flag[2], 0);
    cfg(8'd2, 1'b0);
    check("t3_flag2_hi", flag[2], 1);
    en = 4'b0100;
    tick();
    check("t3_hold2", cnt(2), 5);
    check("t3_ovf2", ovf[2], 1);
    check("t3_hit2", hit[2], 0);
    en = '0; clean = 4'b0100;
    tick();
    clean = '0;
    check("t3_clr_count2", cnt(2), 0);
    check("t3_clr_ovf2", ovf[2], 0);
    check("t3_clr_flag2", flag[2], 0);

    // clean beats en on ch3.
    cfg(8'd100, 1'b0);
    en = 4'b1000;
    repeat (7) tick();
    check("t4_count3", cnt(3), 7);
    clean = 4'b1000;
    tick();
    clean = '0; en = '0;
    check("t4_clr_count3", cnt(3), 0);
    check("t4_clr_hit3", hit[3], 0);

    // max 0: wrap hits every en, saturate overruns.
    clean = 4'b0001;
    cfg(8'd0, 1'b1);
    clean = '0;
    check("t5_pre_ovf0", ovf[0], 0);
    en = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_wrap_count0", cnt(0), 0);
      check("t5_wrap_hit0", hit[0], 1);
      check("t5_wrap_ovf0", ovf[0], 0);
    end
    en = '0;
    cfg(8'd0, 1'b0);
    check("t5_idle_hit0", hit[0], 0);
    en = 4'b0001;
    tick();
    en = '0;
    check("t5_sat_hit0", hit[0], 0);
    check("t5_sat_ovf0", ovf[0], 1);
    check("t5_sat_count0", cnt(0), 0);

    // Mid-run reset restores counts and config.
    cfg(8'd50, 1'b1);
    clean = 4'b1111;
    tick();
    clean = '0;
    en = 4'b1111;
    repeat (10) tick();
    check("t6_count_pre", count, 32'h0a0a0a0a);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_count", count, 0);
    check("t6_rst_hit", hit, 0);
    check("t6_rst_ovf", ovf, 0);
    check("t6_rst_all_flag", all_flag, 0);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hit == 4'b1111) hits++;
    end
    check("t6_hits", hits, 1);
    check("t6_count_max", count, 32'h64646464);
    check("t6_all_flag", all_flag, 1);
    tick();
    en = '0;
    check("t6_sat_count", count, 32'h64646464);
    check("t6_sat_ovf", ovf, 4'hf);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
